// File: rtl/ysyx_22041412_pipe_ctrl.sv
// Pipeline sequencer: stage enables, flush/bubble, PC redirect and register scoreboard.
// Optional perf counters are built when YSYX_22041412_PIPE_PERF_EN is defined.
module ysyx_22041412_pipe_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000000080000000,
    parameter int          CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    input  logic        id_is_mul,
    input  logic        ex_redirect,
    input  logic [63:0] ex_target,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic        mul_done,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_bubble,
    output logic        id_flush,
    output logic        pc_load,
    output logic [63:0] pc_next,
    output logic        issue,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, MUL_WAIT} state_t;

    localparam logic [CNT_W-1:0] PMAX = '1;

    state_t           state;
    logic [CNT_W-1:0] pend [32];
    logic             raw;
    logic             sat;
    logic             stall;

    // Hazards look only at registered counts; a same-cycle retire is not bypassed.
    always_comb begin
        raw = (id_rs1_used && id_rs1 != 5'd0 && pend[id_rs1] != '0) ||
              (id_rs2_used && id_rs2 != 5'd0 && pend[id_rs2] != '0);
        sat = id_rd_wen && id_rd != 5'd0 && pend[id_rd] == PMAX;
        stall = id_valid && (raw || sat);
    end

    always_comb begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_bubble = 1'b1;
        id_flush  = 1'b0;
        pc_load   = 1'b0;
        pc_next   = '0;
        issue     = 1'b0;
        if (!rst) begin
            unique case (state)
                BOOT: begin
                    pc_load  = 1'b1;
                    pc_next  = RESET_PC;
                    if_en    = 1'b1;
                    id_flush = 1'b1;
                end
                RUN: begin
                    if (ex_redirect) begin
                        pc_load  = 1'b1;
                        pc_next  = ex_target;
                        if_en    = 1'b1;
                        id_flush = 1'b1;
                    end else if (!stall) begin
                        if_en     = 1'b1;
                        id_en     = 1'b1;
                        ex_bubble = !id_valid;
                        issue     = id_valid;
                    end
                end
                FLUSH: begin
                    if_en    = 1'b1;
                    id_en    = 1'b1;
                    id_flush = 1'b1;
                end
                MUL_WAIT: ex_bubble = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            unique case (state)
                BOOT:  state <= RUN;
                RUN: begin
                    if (ex_redirect)
                        state <= FLUSH;
                    else if (issue && id_is_mul)
                        state <= MUL_WAIT;
                end
                FLUSH: state <= RUN;
                MUL_WAIT: begin
                    if (mul_done)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Entry 0 is never written after reset, so x0 never looks pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                pend[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                logic inc;
                logic dec;
                inc = issue && id_rd_wen && id_rd == 5'(i);
                dec = wb_wen && wb_rd == 5'(i) && pend[i] != '0;
                if (inc && !dec)
                    pend[i] <= pend[i] + 1'b1;
                else if (dec && !inc)
                    pend[i] <= pend[i] - 1'b1;
            end
        end
    end

`ifdef YSYX_22041412_PIPE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == RUN && stall) || state == MUL_WAIT)
                stall_cnt <= stall_cnt + 32'd1;
            if (state == RUN && ex_redirect)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/ysyx_22041412_pipe_ctrl.md
Name: ysyx_22041412_pipe_ctrl

Overview:
- Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Owns per-stage enables, bubble/flush control, PC redirect selection, a register scoreboard for RAW/WAW hazards, and the multi-cycle multiply stall.
- Sits beside the stage registers; stages only latch when their enable from this block is high.

Parameters:
- RESET_PC, 64'h0000000080000000, PC loaded on the first cycle after reset.
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  5  destination register index.
- id_rd_wen  in  1  instruction writes rd.
- id_is_mul  in  1  instruction uses the multi-cycle multiplier.
- ex_redirect  in  1  EX resolved a jump/taken branch this cycle.
- ex_target  in  64  redirect PC.
- wb_wen  in  1  WB retires a register write this cycle.
- wb_rd  in  5  WB destination.
- mul_done  in  1  multiplier result ready (1-cycle pulse).
- if_en, id_en  out  1  IF/ID stage-register load enables.
- ex_bubble  out  1  EX loads a NOP instead of ID contents.
- id_flush  out  1  invalidate IF/ID contents.
- pc_load  out  1  IF loads pc_next instead of pc+4.
- pc_next  out  64  PC to load when pc_load is set.
- issue  out  1  ID→EX transfer of a real instruction this cycle.
- stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- FSM states are BOOT, RUN, FLUSH and MUL_WAIT.
- While rst is high, state=BOOT and all pending counters are 0. All outputs are 0 except ex_bubble=1.
- BOOT, for one cycle after rst deasserts:
  - pc_load=1, pc_next=RESET_PC, if_en=1, id_flush=1, ex_bubble=1.
  - Next state is RUN.
- RAW hazard: (id_rs1_used & id_rs1!=0 & pend[id_rs1]!=0) | (id_rs2_used & id_rs2!=0 & pend[id_rs2]!=0).
- WAW/saturation hazard: id_rd_wen & id_rd!=0 & pend[id_rd]==max.
- stall = id_valid & (raw | sat).
- RUN:
  - If ex_redirect: pc_load=1, pc_next=ex_target, if_en=1, id_flush=1, ex_bubble=1, issue=0. Go to FLUSH. Redirect has priority over stall and mul.
  - Else if stall: if_en=0, id_en=0, ex_bubble=1, issue=0. Stay in RUN.
  - Else: if_en=id_en=1, ex_bubble=!id_valid, issue=id_valid.
  - If issue & id_is_mul, go to MUL_WAIT.
- FLUSH, one cycle:
  - id_flush=1, ex_bubble=1, if_en=1, id_en=1 (discards the wrong-path fetch), issue=0.
  - Next state is RUN.
- MUL_WAIT:
  - if_en=id_en=0, ex_bubble=0; EX holds the multiply.
  - When mul_done=1, go to RUN. Enables resume the following cycle.
  - ex_redirect is ignored in this state (a mul never redirects).
- Scoreboard:
  - On issue & id_rd_wen & id_rd!=0: pend[id_rd]++.
  - On wb_wen & wb_rd!=0: pend[wb_rd]--.
  - Same register incremented and decremented in the same cycle: net unchanged.
  - pend[0] is constantly 0.
  - A decrement of a 0 counter holds it at 0 (no underflow).
- The hazard check uses pend values registered before this cycle's WB decrement. There is no same-cycle WB bypass, so a source whose last writer retires this cycle still stalls one cycle.
- Reset mid-operation: counters clear immediately, state goes to BOOT, enables go low.
- Counters update only on clk edges while rst=0.

Optional Feature:
- Macro: YSYX_22041412_PIPE_PERF_EN.
- When defined:
  - stall_cnt increments each cycle in RUN with stall=1, or in MUL_WAIT.
  - flush_cnt increments on every ex_redirect accepted in RUN.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset release → BOOT for 1 cycle with pc_load=1 and pc_next=64'h80000000, then RUN; if_en=1 and issue follows id_valid.
- Issue "addi x5" (rd=5), next ID reads rs1=5 → stall held (if_en=0, ex_bubble=1) until wb_wen with wb_rd=5 is seen. issue rises the cycle after that retire; stall_cnt equals the number of stalled cycles.
- ex_redirect=1 with ex_target=64'h80000100 in RUN → same cycle pc_load=1 and pc_next=64'h80000100, id_flush=1 for 2 cycles (redirect + FLUSH), flush_cnt=1, no scoreboard change.
- Issue a mul with id_is_mul=1 → if_en=id_en=0 for N cycles until mul_done; RUN resumes the next cycle. ex_redirect asserted during the wait is ignored.
- Three back-to-back writers to x7 with CNT_W=2 → pend[7]=3. A fourth writer stalls (sat); a WB retire of x7 in the same cycle as a new issue keeps pend[7] unchanged.
- Writes and reads of x0 never stall or count; rst pulsed while pend[5]=2 → pend[5] is 0 immediately and state is BOOT.
